// File: rtl/simple_axi_slave_ram.sv
// Single-beat AXI4 slave terminating all five channels onto a word-addressed RAM.
// Bursts are drained and answered with SLVERR; accesses outside the window get DECERR.
module simple_axi_slave_ram #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    MEM_WORDS  = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                    i_clk,
    input  logic                    i_rst,

    input  logic                    i_axi_awvalid,
    output logic                    o_axi_awready,
    input  logic [ADDR_WIDTH-1:0]   i_axi_awaddr,
    input  logic [7:0]              i_axi_awlen,
    input  logic [2:0]              i_axi_awsize,

    input  logic                    i_axi_wvalid,
    output logic                    o_axi_wready,
    input  logic [DATA_WIDTH-1:0]   i_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_axi_wstrb,
    input  logic                    i_axi_wlast,

    output logic                    o_axi_bvalid,
    input  logic                    i_axi_bready,
    output logic [1:0]              o_axi_bresp,

    input  logic                    i_axi_arvalid,
    output logic                    o_axi_arready,
    input  logic [ADDR_WIDTH-1:0]   i_axi_araddr,
    input  logic [7:0]              i_axi_arlen,
    input  logic [2:0]              i_axi_arsize,

    output logic                    o_axi_rvalid,
    input  logic                    i_axi_rready,
    output logic [DATA_WIDTH-1:0]   o_axi_rdata,
    output logic [1:0]              o_axi_rresp,
    output logic                    o_axi_rlast
);

    localparam int                  BYTES     = DATA_WIDTH / 8;
    localparam int                  SIZE_LOG2 = $clog2(BYTES);
    localparam int                  IDX_W     = $clog2(MEM_WORDS);
    localparam logic [ADDR_WIDTH:0] WIN_LIMIT = (ADDR_WIDTH+1)'(MEM_WORDS * BYTES);
    localparam logic [2:0]          FULL_SIZE = 3'(SIZE_LOG2);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_DRAIN, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    // Addresses below BASE_ADDR wrap to huge offsets and so fail the window compare.
    function automatic logic [ADDR_WIDTH:0] offset_of(input logic [ADDR_WIDTH-1:0] addr);
        return {1'b0, addr} - {1'b0, BASE_ADDR};
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] addr);
        return IDX_W'(offset_of(addr) >> SIZE_LOG2);
    endfunction

    function automatic logic [1:0] resp_for(input logic [ADDR_WIDTH-1:0] addr,
                                            input logic [7:0]            len,
                                            input logic [2:0]            size);
        if (offset_of(addr) >= WIN_LIMIT)            return RESP_DECERR;
        else if (len != 8'd0 || size != FULL_SIZE)   return RESP_SLVERR;
        else                                         return RESP_OKAY;
    endfunction

    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

    w_state_t              w_state;
    logic [ADDR_WIDTH-1:0] aw_addr_q;
    logic [7:0]            aw_len_q;
    logic [2:0]            aw_size_q;
    logic [DATA_WIDTH-1:0] w_data_q;
    logic [BYTES-1:0]      w_strb_q;
    logic                  w_last_q;
    logic [1:0]            wr_resp_q;

    logic                  aw_hs, w_hs;
    logic [ADDR_WIDTH-1:0] eff_awaddr;
    logic [7:0]            eff_awlen;
    logic [2:0]            eff_awsize;
    logic [DATA_WIDTH-1:0] eff_wdata;
    logic [BYTES-1:0]      eff_wstrb;
    logic                  eff_wlast;
    logic                  commit, commit_drain, mem_we;
    logic [1:0]            commit_resp;
    logic [IDX_W-1:0]      wr_idx;

    assign aw_hs = i_axi_awvalid && o_axi_awready;
    assign w_hs  = i_axi_wvalid && o_axi_wready;

    // Each half of a write comes either from its capture register or from the live bus.
    assign eff_awaddr = (w_state == W_HAVE_AW) ? aw_addr_q : i_axi_awaddr;
    assign eff_awlen  = (w_state == W_HAVE_AW) ? aw_len_q  : i_axi_awlen;
    assign eff_awsize = (w_state == W_HAVE_AW) ? aw_size_q : i_axi_awsize;
    assign eff_wdata  = (w_state == W_HAVE_W)  ? w_data_q  : i_axi_wdata;
    assign eff_wstrb  = (w_state == W_HAVE_W)  ? w_strb_q  : i_axi_wstrb;
    assign eff_wlast  = (w_state == W_HAVE_W)  ? w_last_q  : i_axi_wlast;

    assign commit = (w_state == W_IDLE    && aw_hs && w_hs) ||
                    (w_state == W_HAVE_AW && w_hs) ||
                    (w_state == W_HAVE_W  && aw_hs);
    assign commit_resp  = resp_for(eff_awaddr, eff_awlen, eff_awsize);
    assign commit_drain = (eff_awlen != 8'd0) && !eff_wlast;
    assign mem_we       = commit && (commit_resp == RESP_OKAY);
    assign wr_idx       = word_idx(eff_awaddr);

    // NOTE: all state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            w_state       <= W_IDLE;
            o_axi_awready <= 1'b0;
            o_axi_wready  <= 1'b0;
            o_axi_bvalid  <= 1'b0;
            o_axi_bresp   <= RESP_OKAY;
            wr_resp_q     <= RESP_OKAY;
            aw_addr_q     <= '0;
            aw_len_q      <= '0;
            aw_size_q     <= '0;
            w_data_q      <= '0;
            w_strb_q      <= '0;
            w_last_q      <= 1'b0;
        end else if (commit) begin
            o_axi_awready <= 1'b0;
            if (commit_drain) begin
                w_state      <= W_DRAIN;
                wr_resp_q    <= commit_resp;
                o_axi_wready <= 1'b1;
            end else begin
                w_state      <= W_RESP;
                o_axi_wready <= 1'b0;
                o_axi_bvalid <= 1'b1;
                o_axi_bresp  <= commit_resp;
            end
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (aw_hs) begin
                        aw_addr_q     <= i_axi_awaddr;
                        aw_len_q      <= i_axi_awlen;
                        aw_size_q     <= i_axi_awsize;
                        wr_resp_q     <= resp_for(i_axi_awaddr, i_axi_awlen, i_axi_awsize);
                        w_state       <= (i_axi_awlen != 8'd0) ? W_DRAIN : W_HAVE_AW;
                        o_axi_awready <= 1'b0;
                        o_axi_wready  <= 1'b1;
                    end else if (w_hs) begin
                        w_data_q      <= i_axi_wdata;
                        w_strb_q      <= i_axi_wstrb;
                        w_last_q      <= i_axi_wlast;
                        w_state       <= W_HAVE_W;
                        o_axi_awready <= 1'b1;
                        o_axi_wready  <= 1'b0;
                    end else begin
                        o_axi_awready <= 1'b1;
                        o_axi_wready  <= 1'b1;
                    end
                end
                W_DRAIN: begin
                    if (w_hs && i_axi_wlast) begin
                        w_state      <= W_RESP;
                        o_axi_wready <= 1'b0;
                        o_axi_bvalid <= 1'b1;
                        o_axi_bresp  <= wr_resp_q;
                    end
                end
                W_RESP: begin
                    if (i_axi_bready) begin
                        w_state       <= W_IDLE;
                        o_axi_bvalid  <= 1'b0;
                        o_axi_bresp   <= RESP_OKAY;
                        o_axi_awready <= 1'b1;
                        o_axi_wready  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: the RAM array has no reset; its contents survive i_rst and map onto plain memory.
    always_ff @(posedge i_clk) begin
        if (mem_we) begin
            for (int b = 0; b < BYTES; b++) begin
                if (eff_wstrb[b]) mem[wr_idx][8*b +: 8] <= eff_wdata[8*b +: 8];
            end
        end
    end

    r_state_t   r_state;
    logic [7:0] rd_cnt;
    logic       ar_hs;
    logic [1:0] ar_resp;

    assign ar_hs   = i_axi_arvalid && o_axi_arready;
    assign ar_resp = resp_for(i_axi_araddr, i_axi_arlen, i_axi_arsize);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= R_IDLE;
            rd_cnt        <= '0;
            o_axi_arready <= 1'b0;
            o_axi_rvalid  <= 1'b0;
            o_axi_rdata   <= '0;
            o_axi_rresp   <= RESP_OKAY;
            o_axi_rlast   <= 1'b0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (ar_hs) begin
                        r_state       <= R_DATA;
                        rd_cnt        <= i_axi_arlen;
                        o_axi_arready <= 1'b0;
                        o_axi_rvalid  <= 1'b1;
                        o_axi_rresp   <= ar_resp;
                        o_axi_rlast   <= (i_axi_arlen == 8'd0);
                        o_axi_rdata   <= (ar_resp == RESP_OKAY) ? mem[word_idx(i_axi_araddr)] : '0;
                    end else begin
                        o_axi_arready <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (i_axi_rready) begin
                        if (rd_cnt == 8'd0) begin
                            r_state       <= R_IDLE;
                            o_axi_arready <= 1'b1;
                            o_axi_rvalid  <= 1'b0;
                            o_axi_rdata   <= '0;
                            o_axi_rresp   <= RESP_OKAY;
                            o_axi_rlast   <= 1'b0;
                        end else begin
                            rd_cnt      <= rd_cnt - 8'd1;
                            o_axi_rlast <= (rd_cnt == 8'd1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/simple_axi_slave_ram.md
Name: simple_axi_slave_ram

Overview:
- AXI4 slave that sits directly downstream of the single-beat AXI master and terminates its five channels.
- Backed by a word-addressed RAM, so the master can be brought up and regressed without external IP.
- Write and read channels run independently.
- Supports single-beat transfers; bursts are drained and answered with SLVERR; out-of-window addresses get DECERR.

Parameters:
DATA_WIDTH, 32, data bus width in bits (multiple of 8)
ADDR_WIDTH, 32, AXI address width
MEM_WORDS, 1024, RAM depth in DATA_WIDTH words (power of two)
BASE_ADDR, 0, byte address of word 0; window = [BASE_ADDR, BASE_ADDR + MEM_WORDS*DATA_WIDTH/8)

Ports:
i_clk  in  1  global clock
i_rst  in  1  global reset, asynchronous, active-high
i_axi_awvalid / o_axi_awready  in/out  1  AW handshake
i_axi_awaddr  in  ADDR_WIDTH  write byte address
i_axi_awlen  in  8  beats-1
i_axi_awsize  in  3  bytes per beat, log2
i_axi_wvalid / o_axi_wready  in/out  1  W handshake
i_axi_wdata  in  DATA_WIDTH  write data
i_axi_wstrb  in  DATA_WIDTH/8  byte enables
i_axi_wlast  in  1  last W beat
o_axi_bvalid / i_axi_bready  out/in  1  B handshake
o_axi_bresp  out  2  write response
i_axi_arvalid / o_axi_arready  in/out  1  AR handshake
i_axi_araddr  in  ADDR_WIDTH  read byte address
i_axi_arlen  in  8  beats-1
i_axi_arsize  in  3  bytes per beat, log2
o_axi_rvalid / i_axi_rready  out/in  1  R handshake
o_axi_rdata  out  DATA_WIDTH  read data
o_axi_rresp  out  2  read response
o_axi_rlast  out  1  last R beat

Behaviour:
- Reset: asynchronous and active-high on i_rst. While asserted, all valids and readies are 0, bresp/rresp are 00, rdata is 0 and rlast is 0. RAM contents are not reset.
- From the first edge after deassertion, awready=1, wready=1 and arready=1. Reset mid-transaction drops all pending state; no response is issued.
- Word index = (addr - BASE_ADDR) >> log2(DATA_WIDTH/8). Low address bits are ignored, so accesses are aligned down.
- Write path states: W_IDLE, W_HAVE_AW, W_HAVE_W, W_DRAIN, W_RESP.
  - awready=1 in W_IDLE and W_HAVE_W. wready=1 in W_IDLE, W_HAVE_AW and W_DRAIN.
  - AW handshake captures addr/len/size. W handshake captures data/strb.
  - Commit happens on the edge where both AW and W are available, either captured or handshaking that cycle; simultaneous AW+W in W_IDLE commits on that edge.
  - On commit, bytes with strb=1 are written only when resp=OKAY. State then goes to W_RESP and bvalid=1 from the next cycle.
  - bresp priority: DECERR if out of window; else SLVERR if len!=0 or size!=log2(DATA_WIDTH/8); else OKAY.
  - len!=0 on AW: go to W_DRAIN, accept and discard W beats until a beat with wlast=1, then W_RESP with SLVERR.
  - W_RESP holds bvalid/bresp stable until bready=1, then returns to W_IDLE. No new AW/W is accepted while in W_RESP.
- Read path states: R_IDLE, R_DATA.
  - arready=1 only in R_IDLE. An AR handshake loads the beat counter with arlen.
  - The RAM word is read on the AR handshake edge into rdata.
  - rvalid=1 from the next cycle, with rresp by the same priority as writes.
  - rdata=0 for any non-OKAY beat.
  - R_DATA holds rvalid/rdata/rresp/rlast stable until rready=1. Each R handshake decrements the counter.
  - rlast=1 when counter==0; the handshake on that beat returns to R_IDLE. Burst beats carry SLVERR (or DECERR) with zero data.
  - Read latency from AR handshake to rvalid is 1 cycle; back-to-back singles give one beat every 2 cycles.
- Simultaneous events:
  - A read and a write to the same word committing on the same edge: the read returns the old data.
  - Write and read paths never stall each other.
- Response codes: OKAY=00, SLVERR=10, DECERR=11. EXOKAY is never returned.

Test Plan:
- Reset asserted asynchronously mid-cycle -> all valids/readies 0 immediately. After release -> awready=wready=arready=1.
- AW 0x10 + W 0xDEADBEEF with strb 0xF in the same cycle, bready=1 -> bvalid next cycle, bresp=00. AR 0x10 -> rvalid 1 cycle after the handshake, rdata=0xDEADBEEF, rresp=00, rlast=1.
- AW sent 3 cycles before W, strb=0x3 with data 0x12345678 over a word holding 0xDEADBEEF -> readback 0xDEAD5678.
- W sent before AW, and bready held 0 for 5 cycles -> bvalid stays 1 with bresp stable; awready=wready=0 until the B handshake.
- AW/AR at BASE_ADDR+4*MEM_WORDS -> bresp=11, RAM unchanged; rresp=11, rdata=0.
- AR arlen=3 with rready toggling -> exactly 4 beats, each rresp=10, rlast only on the 4th. AW awlen=1 -> 2 W beats consumed, a single B with bresp=10.
